fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the PC register, drives the memory's byte address, and captures the returned 32-bit big-endian word into the IF/ID pipeline register.
- Supports stall, branch redirect, flush and a sticky halt.
- Decode sits downstream and consumes if_id_*.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_stage_if_id_reg.sv | 47 ++++
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and FSM state type for the instruction-fetch stage.
package fetch_pkg;

    localparam int          XLEN           = 32;
    localparam logic [31:0] NOP_WORD       = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF   = 32'd100;
    localparam int          IMEM_BYTES_DEF = 256;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid with load/bubble/hold control.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] BUBBLE_WORD = NOP_WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_bubble,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc4,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc4,
    output logic            o_valid
);

    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc4;
    logic            r_valid;

    // Bubble beats load; pc4 is left untouched by a bubble since valid=0 marks it stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr <= BUBBLE_WORD;
            r_pc4   <= {XLEN{1'b0}};
            r_valid <= 1'b0;
        end else if (i_bubble) begin
            r_instr <= BUBBLE_WORD;
            r_pc4   <= r_pc4;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end else begin
            r_instr <= r_instr;
            r_pc4   <= r_pc4;
            r_valid <= r_valid;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, RUN/HALT FSM, redirect/flush/stall priority.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          IMEM_BYTES = IMEM_BYTES_DEF,
    parameter logic [31:0] NOP_WORD   = fetch_pkg::NOP_WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            flush,
    input  logic            halt,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_data,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc4,
    output logic            if_id_valid,
    output logic [XLEN-1:0] pc,
    output logic            halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] cyc_cnt,
    output logic [XLEN-1:0] fetch_cnt
`endif
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_pc4;
    logic            w_in_range;
    logic            w_load;
    logic            w_bubble;

    assign w_pc4      = r_pc + 32'd4;
    assign w_in_range = (r_pc <= 32'(IMEM_BYTES - 4));
    assign imem_addr  = {r_pc[31:2], 2'b00};

    // Next-state, next-PC and IF/ID control in priority order: branch, halt, flush, stall, fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        w_bubble    = 1'b0;
        case (r_state)
            RUN: begin
                if (branch_taken) begin
                    w_pc_nxt = branch_target & ~32'h0000_0003;
                    w_bubble = 1'b1;
                end else if (halt) begin
                    w_state_nxt = HALT;
                    w_bubble    = 1'b1;
                end else if (flush) begin
                    w_bubble = 1'b1;
                    if (stall) begin
                        w_pc_nxt = r_pc;
                    end else begin
                        w_pc_nxt = w_pc4;
                    end
                end else if (stall) begin
                    w_pc_nxt = r_pc;
                end else begin
                    w_pc_nxt = w_pc4;
                    if (w_in_range) begin
                        w_load = 1'b1;
                    end else begin
                        w_bubble = 1'b1;
                    end
                end
            end
            HALT: begin
                w_bubble = 1'b1;
            end
            default: begin
                w_state_nxt = RUN;
                w_bubble    = 1'b1;
            end
        endcase
    end

    // PC and FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_state <= RUN;
        end else begin
            r_pc    <= w_pc_nxt;
            r_state <= w_state_nxt;
        end
    end

    if_id_reg #(
        .BUBBLE_WORD (NOP_WORD)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_instr  (imem_data),
        .i_pc4    (w_pc4),
        .o_instr  (if_id_instr),
        .o_pc4    (if_id_pc4),
        .o_valid  (if_id_valid)
    );

    assign pc     = r_pc;
    assign halted = (r_state == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] r_cyc_cnt;
    logic [XLEN-1:0] r_fetch_cnt;

    // Saturating counters; HALT stops both since neither RUN nor a load occurs there.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc_cnt   <= {XLEN{1'b0}};
            r_fetch_cnt <= {XLEN{1'b0}};
        end else begin
            if ((r_state == RUN) && (r_cyc_cnt != 32'hFFFF_FFFF)) begin
                r_cyc_cnt <= r_cyc_cnt + 32'd1;
            end else begin
                r_cyc_cnt <= r_cyc_cnt;
            end
            if (w_load && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end else begin
                r_fetch_cnt <= r_fetch_cnt;
            end
        end
    end

    assign cyc_cnt   = r_cyc_cnt;
    assign fetch_cnt = r_fetch_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a 256-byte big-endian memory model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        flush;
    logic        halt;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] pc;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cyc_cnt;
    logic [31:0] fetch_cnt;
`endif

    logic [7:0] mem [0:255];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .flush         (flush),
        .halt          (halt),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .pc            (pc),
        .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .cyc_cnt       (cyc_cnt),
        .fetch_cnt     (fetch_cnt)
`endif
    );

    // Out-of-range reads return a non-zero pattern so NOP injection is visible.
    always_comb begin
        if (imem_addr <= 32'd252) begin
            imem_data = {mem[imem_addr[7:0]], mem[imem_addr[7:0] + 8'd1],
                         mem[imem_addr[7:0] + 8'd2], mem[imem_addr[7:0] + 8'd3]};
        end else begin
            imem_data = 32'hDEAD_BEEF;
        end
    end

    task automatic put_word(input int a, input logic [31:0] w);
        mem[a]   = w[31:24];
        mem[a+1] = w[23:16];
        mem[a+2] = w[15:8];
        mem[a+3] = w[7:0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        flush = 1'b0; halt = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        chk("reset_pc", pc, 32'd100);
        chk("reset_imem_addr", imem_addr, 32'd100);
        chk("reset_instr", if_id_instr, 32'h0000_0000);
        chk("reset_pc4", if_id_pc4, 32'd0);
        chk("reset_valid", {31'd0, if_id_valid}, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
    endtask

    task automatic test_fetch();
        step();
        chk("fetch1_instr", if_id_instr, 32'h0022_1820);
        chk("fetch1_pc4", if_id_pc4, 32'd104);
        chk("fetch1_valid", {31'd0, if_id_valid}, 32'd1);
        chk("fetch1_pc", pc, 32'd104);
        step();
        chk("fetch2_instr", if_id_instr, 32'h1000_0068);
        step();
        chk("fetch3_instr", if_id_instr, 32'h1000_006C);
        chk("fetch3_pc", pc, 32'd112);
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_pc", pc, 32'd112);
            chk("stall_instr", if_id_instr, 32'h1000_006C);
            chk("stall_pc4", if_id_pc4, 32'd112);
            chk("stall_valid", {31'd0, if_id_valid}, 32'd1);
        end
        stall = 1'b0;
        step();
        chk("unstall_instr", if_id_instr, 32'h0123_2022);
        chk("unstall_pc4", if_id_pc4, 32'd116);
        chk("unstall_pc", pc, 32'd116);
    endtask

    task automatic test_branch();
        branch_taken = 1'b1; branch_target = 32'd118; stall = 1'b1;
        step();
        branch_taken = 1'b0; stall = 1'b0;
        chk("branch_pc", pc, 32'd116);
        chk("branch_instr", if_id_instr, 32'h0000_0000);
        chk("branch_valid", {31'd0, if_id_valid}, 32'd0);
        step();
        chk("post_branch_instr", if_id_instr, 32'h0069_2825);
        chk("post_branch_pc4", if_id_pc4, 32'd120);
        chk("post_branch_pc", pc, 32'd120);
    endtask

    task automatic test_flush();
        flush = 1'b1;
        step();
        chk("flush_pc", pc, 32'd124);
        chk("flush_valid", {31'd0, if_id_valid}, 32'd0);
        chk("flush_instr", if_id_instr, 32'h0000_0000);
        stall = 1'b1;
        step();
        flush = 1'b0; stall = 1'b0;
        chk("flush_stall_pc", pc, 32'd124);
        chk("flush_stall_valid", {31'd0, if_id_valid}, 32'd0);
    endtask

    task automatic test_boundary();
        branch_taken = 1'b1; branch_target = 32'd248;
        step();
        branch_taken = 1'b0;
        step();
        chk("b248_instr", if_id_instr, 32'h1000_00F8);
        chk("b248_pc", pc, 32'd252);
        step();
        chk("b252_instr", if_id_instr, 32'h1000_00FC);
        chk("b252_valid", {31'd0, if_id_valid}, 32'd1);
        chk("b252_pc", pc, 32'd256);
        chk("b256_addr", imem_addr, 32'd256);
        step();
        chk("b256_instr", if_id_instr, 32'h0000_0000);
        chk("b256_valid", {31'd0, if_id_valid}, 32'd0);
        chk("b256_pc", pc, 32'd260);
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        step();
        branch_taken = 1'b0;
        chk("wrap_target_pc", pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc", pc, 32'd0);
        chk("wrap_valid", {31'd0, if_id_valid}, 32'd0);
        step();
        chk("wrap0_instr", if_id_instr, 32'h1000_0000);
        chk("wrap0_pc4", if_id_pc4, 32'd4);
    endtask

    task automatic test_halt();
        halt = 1'b1; branch_taken = 1'b1; branch_target = 32'd120;
        step();
        branch_taken = 1'b0;
        chk("halt_br_pc", pc, 32'd120);
        chk("halt_br_halted", {31'd0, halted}, 32'd0);
        step();
        halt = 1'b0;
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_pc", pc, 32'd120);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("halt_hold_pc", pc, 32'd120);
            chk("halt_hold_valid", {31'd0, if_id_valid}, 32'd0);
            chk("halt_hold_halted", {31'd0, halted}, 32'd1);
        end
        do_reset();
        chk("halt_rst_pc", pc, 32'd100);
        chk("halt_rst_halted", {31'd0, halted}, 32'd0);
        step();
        chk("halt_stall_pre_valid", {31'd0, if_id_valid}, 32'd1);
        halt = 1'b1; stall = 1'b1;
        step();
        halt = 1'b0; stall = 1'b0;
        chk("halt_stall_halted", {31'd0, halted}, 32'd1);
        chk("halt_stall_valid", {31'd0, if_id_valid}, 32'd0);
        chk("halt_stall_pc", pc, 32'd104);
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        chk("perf_rst_cyc", cyc_cnt, 32'd0);
        chk("perf_rst_fetch", fetch_cnt, 32'd0);
        for (int i = 0; i < 10; i++) begin
            stall = (i == 4) ? 1'b1 : 1'b0;
            step();
        end
        stall = 1'b0;
        chk("perf_cyc", cyc_cnt, 32'd10);
        chk("perf_fetch", fetch_cnt, 32'd9);
        halt = 1'b1;
        step();
        halt = 1'b0;
        step();
        step();
        chk("perf_halt_cyc", cyc_cnt, 32'd11);
        chk("perf_halt_fetch", fetch_cnt, 32'd9);
        do_reset();
        chk("perf_rst2_cyc", cyc_cnt, 32'd0);
        chk("perf_rst2_fetch", fetch_cnt, 32'd0);
    endtask
`endif

    initial begin
        for (int a = 0; a < 256; a += 4) begin
            put_word(a, 32'h1000_0000 + 32'(a));
        end
        put_word(100, 32'h0022_1820);
        put_word(112, 32'h0123_2022);
        put_word(116, 32'h0069_2825);
        test_reset();
        test_fetch();
        test_stall();
        test_branch();
        test_flush();
        test_boundary();
        test_halt();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
